me_result_writer: RTL and testbench



---
 rtl/me_result_writer.sv | 186 ++++++++++++++++++
 tb/tb_me_result_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/me_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : me_result_writer
// Brief    : Captures motion-estimation results on data_valid rising edges,
//            buffers them in a small FIFO and writes packed result words to
//            memory with a valid/ready handshake and a per-frame done pulse.
//            Optional macro ME_RESULT_MV_SIGNED_EN packs the column and row
//            fields as signed offsets from the search-window centre.
// Revision : 1.0 - initial release
// ============================================================================
module me_result_writer #(
    parameter int          SAD_BIT_WIDTH    = 14,
    parameter int          FIFO_DEPTH       = 4,
    parameter int          BLOCKS_PER_FRAME = 16,
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
    parameter int          MV_OFFSET        = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SAD_BIT_WIDTH-1:0] MSAD,
    input  logic [4:0]               MSAD_column,
    input  logic [4:0]               MSAD_row,
    input  logic                     data_valid,
    output logic [31:0]              wr_addr,
    output logic [31:0]              wr_data,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic                     frame_done,
    output logic                     overflow
);

    localparam int         c_AW      = $clog2(FIFO_DEPTH);
    localparam int         c_PW      = c_AW + 1;
    localparam logic [7:0] c_IDX_MAX = 8'(BLOCKS_PER_FRAME - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [4:0]      w_col;
    logic [4:0]      w_row;
    logic            w_edge;
    logic            r_dv_prev;
    logic            r_armed;
    logic            r_cap_valid;
    logic [31:0]     r_cap_word;
    logic [7:0]      r_blk_idx;

    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_PW-1:0] w_count;
    logic            w_empty;
    logic            w_full;
    logic            w_has_next;
    logic            w_push;
    logic            w_pop;
    logic [c_AW-1:0] w_ridx;
    logic [c_AW-1:0] w_ridx_next;
    logic [31:0]     w_head;
    logic [31:0]     w_next;

    logic [1:0]      r_state;
    logic [7:0]      r_wr_cnt;

`ifdef ME_RESULT_MV_SIGNED_EN
    localparam logic [4:0] c_MV_OFF = 5'(MV_OFFSET);
    assign w_col = MSAD_column - c_MV_OFF;
    assign w_row = MSAD_row - c_MV_OFF;
`else
    assign w_col = MSAD_column;
    assign w_row = MSAD_row;
`endif

    // r_armed blocks a level that was already high at reset release until it drops once
    assign w_edge = data_valid & ~r_dv_prev & r_armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dv_prev   <= 1'b0;
            r_armed     <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_word  <= 32'd0;
            r_blk_idx   <= 8'd0;
        end else begin
            r_dv_prev   <= data_valid;
            r_cap_valid <= w_edge;
            if (!data_valid) begin
                r_armed <= 1'b1;
            end
            if (w_edge) begin
                r_cap_word <= {MSAD[13:0], w_col, w_row, r_blk_idx};
                r_blk_idx  <= (r_blk_idx == c_IDX_MAX) ? 8'd0 : r_blk_idx + 8'd1;
            end
        end
    end

    // Head stays in the FIFO until accepted, so the word on the bus occupies a slot
    assign w_count     = r_wptr - r_rptr;
    assign w_empty     = (w_count == '0);
    assign w_full      = (w_count == c_PW'(FIFO_DEPTH));
    assign w_has_next  = (w_count > c_PW'(1));
    assign w_pop       = (r_state == S_SEND) & wr_ready;
    assign w_push      = r_cap_valid & (~w_full | w_pop);
    assign w_ridx      = r_rptr[c_AW-1:0];
    assign w_ridx_next = w_ridx + c_AW'(1);
    assign w_head      = r_mem[w_ridx];
    assign w_next      = r_mem[w_ridx_next];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= r_cap_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            if (r_cap_valid && !w_push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wr_cnt   <= 8'd0;
            wr_addr    <= BASE_ADDR;
            wr_data    <= 32'd0;
            wr_valid   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    frame_done <= 1'b0;
                    if (!w_empty) begin
                        wr_data  <= w_head;
                        wr_valid <= 1'b1;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (wr_ready) begin
                        wr_addr <= wr_addr + 32'd4;
                        if (r_wr_cnt == c_IDX_MAX) begin
                            wr_valid   <= 1'b0;
                            frame_done <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 8'd1;
                            if (w_has_next) begin
                                wr_data <= w_next;
                            end else begin
                                wr_valid <= 1'b0;
                                r_state  <= S_IDLE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    wr_addr    <= BASE_ADDR;
                    r_wr_cnt   <= 8'd0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    wr_valid   <= 1'b0;
                    frame_done <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_me_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_me_result_writer
// Brief    : Directed self-checking bench for me_result_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_me_result_writer;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] msad;
    logic [4:0]  col;
    logic [4:0]  row;
    logic        dv;
    logic        ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        frame_done;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    me_result_writer #(
        .SAD_BIT_WIDTH   (14),
        .FIFO_DEPTH      (4),
        .BLOCKS_PER_FRAME(16),
        .BASE_ADDR       (BASE),
        .MV_OFFSET       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MSAD       (msad),
        .MSAD_column(col),
        .MSAD_row   (row),
        .data_valid (dv),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (ready),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected word layout: {MSAD[13:0], col[4:0], row[4:0], blk_idx[7:0]}
    function automatic logic [31:0] pack(input int m, input int c, input int r, input int b);
        logic [4:0] cc;
        logic [4:0] rr;
        cc = 5'(c);
        rr = 5'(r);
`ifdef ME_RESULT_MV_SIGNED_EN
        cc = 5'(c - 8);
        rr = 5'(r - 8);
`endif
        return {14'(m), cc, rr, 8'(b)};
    endfunction

    task automatic wait_valid();
        int n;
        n = 0;
        while (!wr_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk1("valid_within_bound", wr_valid, 1'b1);
    endtask

    task automatic pulse(input int m, input int c, input int r);
        msad = 14'(m);
        col  = 5'(c);
        row  = 5'(r);
        dv   = 1'b1;
        @(negedge clk);
        dv   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int   nacc;
        logic seen;

        rst = 1'b0; dv = 1'b0; ready = 1'b0;
        msad = '0; col = '0; row = '0;
        repeat (3) @(negedge clk);
        chk1("rst_wr_valid", wr_valid, 1'b0);
        chk1("rst_frame_done", frame_done, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_wr_addr", wr_addr, BASE);
        rst = 1'b1;
        @(negedge clk);

        // single result, two-cycle latency
        ready = 1'b1;
        pulse(100, 3, 5);
        chk1("lat_cycle1", wr_valid, 1'b0);
        @(negedge clk);
        chk1("lat_cycle2", wr_valid, 1'b0);
        @(negedge clk);
        chk1("single_valid", wr_valid, 1'b1);
        chk("single_data", wr_data, pack(100, 3, 5, 0));
        chk("single_addr", wr_addr, BASE);
        @(negedge clk);
        chk1("single_done_valid", wr_valid, 1'b0);
        chk("single_next_addr", wr_addr, BASE + 32'd4);

        // back-pressure: held stable for 10 cycles, accepted on the 11th
        ready = 1'b0;
        pulse(7, 1, 2);
        wait_valid();
        chk("stall_data0", wr_data, pack(7, 1, 2, 1));
        repeat (10) begin
            @(negedge clk);
            chk1("stall_valid", wr_valid, 1'b1);
            chk("stall_data", wr_data, pack(7, 1, 2, 1));
            chk("stall_addr", wr_addr, BASE + 32'd4);
        end
        ready = 1'b1;
        @(negedge clk);
        chk1("stall_released", wr_valid, 1'b0);
        chk("stall_next_addr", wr_addr, BASE + 32'd8);

        // overflow: five results against a four-deep FIFO with no acceptance
        ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse(20 + i, i, i + 2);
            @(negedge clk);
        end
        @(negedge clk);
        chk1("ovf_set", overflow, 1'b1);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk1("ovf_drain_valid", wr_valid, 1'b1);
            chk("ovf_drain_data", wr_data, pack(20 + i, i, i + 2, i));
            chk("ovf_drain_addr", wr_addr, BASE + 32'(4 * i));
            @(negedge clk);
        end
        chk1("ovf_drained", wr_valid, 1'b0);
        chk1("ovf_sticky", overflow, 1'b1);

        // full frame of 16 results
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pulse(3 * i + 1, i + 1, 15 - i);
            wait_valid();
            chk("frame_data", wr_data, pack(3 * i + 1, i + 1, 15 - i, i));
            chk("frame_addr", wr_addr, BASE + 32'(4 * i));
            @(negedge clk);
            chk1("frame_done_pulse", frame_done, (i == 15));
        end
        @(negedge clk);
        chk1("frame_done_single", frame_done, 1'b0);
        chk("frame_addr_reload", wr_addr, BASE);
        pulse(5, 2, 2);
        wait_valid();
        chk("frame2_data", wr_data, pack(5, 2, 2, 0));
        chk("frame2_addr", wr_addr, BASE);
        @(negedge clk);

        // data_valid already high at reset release, then held high 20 cycles
        rst = 1'b0;
        dv  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (wr_valid) seen = 1'b1;
        end
        chk1("held_at_release_no_capture", seen, 1'b0);
        dv = 1'b0;
        @(negedge clk);
        msad = 14'd9; col = 5'd4; row = 5'd6;
        dv   = 1'b1;
        nacc = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_valid) begin
                nacc++;
                chk("held_data", wr_data, pack(9, 4, 6, 0));
            end
        end
        dv = 1'b0;
        chk("held_single_capture", 32'(nacc), 32'd1);

        // reset in the middle of a pending write with one more word queued
        ready = 1'b0;
        @(negedge clk);
        pulse(11, 1, 1);
        @(negedge clk);
        pulse(12, 2, 2);
        wait_valid();
        chk("abort_pre_data", wr_data, pack(11, 1, 1, 1));
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk1("abort_valid_now", wr_valid, 1'b0);
        chk("abort_addr_now", wr_addr, BASE);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk1("abort_fifo_flushed", wr_valid, 1'b0);
        ready = 1'b1;
        pulse(13, 3, 3);
        wait_valid();
        chk("after_abort_data", wr_data, pack(13, 3, 3, 0));
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
